// File: rtl/frame_record_pkg.sv
// rtl/frame_record_pkg.sv - shared states and geometry helpers for the ping-pong frame recorder
package frame_record_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_CAPTURE  = 2'd2
  } state_t;

  function automatic int frame_words(input int x, input int y);
    return x * y;
  endfunction

  // True when ADDR_W can address both frame banks without wrapping.
  function automatic bit addr_w_fits(input int addr_w, input int x, input int y);
    longint cap;
    cap = longint'(1) << addr_w;
    return cap >= longint'(2) * longint'(x) * longint'(y);
  endfunction

endpackage

// File: rtl/frame_record_pp_if.sv
// rtl/frame_record_pp_if.sv - pixel-word input strobes and frame-buffer RAM write port
interface frame_record_pp_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 20
);
  logic              record;
  logic              end_line;
  logic              end_frame;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] write_addr;
  logic              we;
  logic [DATA_W-1:0] data_out;

  modport master (
    output record, end_line, end_frame, data_in,
    input  write_addr, we, data_out
  );

  modport slave (
    input  record, end_line, end_frame, data_in,
    output write_addr, we, data_out
  );
endinterface

// File: rtl/frame_addr_gen.sv
// rtl/frame_addr_gen.sv - line/word counters, row mapping and registered RAM write stage
module frame_addr_gen
  import frame_record_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int X_COUNT   = 240,
  parameter int Y_COUNT   = 1920,
  parameter int BOTTOM_UP = 1,
  parameter int ADDR_W    = 20
) (
  input  logic              pclock,
  input  logic              reset,
  input  logic              capture,
  input  logic              start,
  input  logic              record,
  input  logic              end_line,
  input  logic              end_frame,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_bank,
  output logic [ADDR_W-1:0] write_addr,
  output logic              we,
  output logic [DATA_W-1:0] data_out,
  output logic              drop,
  output logic              last_line
);

  localparam int XC_W = $clog2(X_COUNT + 1);
  localparam int LC_W = $clog2(Y_COUNT + 1);
  localparam logic [XC_W-1:0]   X_MAX    = XC_W'(X_COUNT);
  localparam logic [LC_W-1:0]   Y_MAX    = LC_W'(Y_COUNT);
  localparam logic [LC_W-1:0]   Y_LAST   = LC_W'(Y_COUNT - 1);
  localparam logic [ADDR_W-1:0] BANK_OFF = ADDR_W'(frame_words(X_COUNT, Y_COUNT));

  logic [XC_W-1:0]   xc;
  logic [LC_W-1:0]   lc;
  logic              in_range;
  logic              wr_ok;
  logic [ADDR_W-1:0] lc_a;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] addr;

  assign in_range  = (xc < X_MAX) && (lc < Y_MAX);
  assign wr_ok     = capture && record && in_range;
  assign drop      = capture && record && !in_range;
  assign last_line = capture && (lc == Y_LAST);

  // Row is only meaningful while lc < Y_COUNT; the wrapped value is never written.
  assign lc_a = ADDR_W'(lc);
  assign row  = (BOTTOM_UP != 0) ? (ADDR_W'(Y_COUNT - 1) - lc_a) : lc_a;
  assign addr = (wr_bank ? BANK_OFF : '0) + row * ADDR_W'(X_COUNT) + ADDR_W'(xc);

  // The word on a strobe cycle uses the pre-strobe counters; strobes then win over xc++.
  always_ff @(posedge pclock) begin
    if (reset) begin
      xc <= '0;
      lc <= '0;
    end else if (start || (capture && end_frame)) begin
      xc <= '0;
      lc <= '0;
    end else if (capture && end_line) begin
      xc <= '0;
      if (lc != Y_MAX) lc <= lc + LC_W'(1);
    end else if (wr_ok) begin
      xc <= xc + XC_W'(1);
    end
  end

  always_ff @(posedge pclock) begin
    if (reset) begin
      we         <= 1'b0;
      write_addr <= '0;
      data_out   <= '0;
    end else begin
      we <= wr_ok;
      if (wr_ok) begin
        write_addr <= addr;
        data_out   <= data_in;
      end
    end
  end

endmodule

// File: rtl/frame_record_pp.sv
// rtl/frame_record_pp.sv - ping-pong frame recorder: capture FSM, bank swap, overflow and frame-done
module frame_record_pp
  import frame_record_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int X_COUNT   = 240,
  parameter int Y_COUNT   = 1920,
  parameter int BOTTOM_UP = 1,
  parameter int ADDR_W    = 20
) (
  input  logic              pclock,
  input  logic              reset,
  input  logic              arm,
  input  logic              continuous,
  frame_record_pp_if.slave  bus,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              frame_done,
  output logic              busy,
  output logic              last_line,
  output logic              overflow
);

  generate
    if (!addr_w_fits(ADDR_W, X_COUNT, Y_COUNT)) begin : g_addr_w_check
      $error("frame_record_pp: ADDR_W too narrow for two frame banks");
    end
  endgenerate

  state_t state;
  state_t state_nx;
  logic   capture;
  logic   start;
  logic   arm_ok;
  logic   drop;

  assign capture = (state == ST_CAPTURE);
  assign start   = (state == ST_WAIT_SOF) && bus.end_frame;
  assign arm_ok  = (state == ST_IDLE) && arm;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge pclock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (arm) state_nx = ST_WAIT_SOF;
      ST_WAIT_SOF: if (bus.end_frame) state_nx = ST_CAPTURE;
      ST_CAPTURE:  if (bus.end_frame) state_nx = continuous ? ST_CAPTURE : ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  // Banks swap on the same edge that raises frame_done, so readout can start immediately.
  always_ff @(posedge pclock) begin
    if (reset) begin
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= capture && bus.end_frame;
      if (capture && bus.end_frame) begin
        rd_bank <= wr_bank;
        wr_bank <= ~wr_bank;
      end
    end
  end

  always_ff @(posedge pclock) begin
    if (reset)       overflow <= 1'b0;
    else if (arm_ok) overflow <= 1'b0;
    else if (drop)   overflow <= 1'b1;
  end

  frame_addr_gen #(
    .DATA_W    (DATA_W),
    .X_COUNT   (X_COUNT),
    .Y_COUNT   (Y_COUNT),
    .BOTTOM_UP (BOTTOM_UP),
    .ADDR_W    (ADDR_W)
  ) u_addr_gen (
    .pclock     (pclock),
    .reset      (reset),
    .capture    (capture),
    .start      (start),
    .record     (bus.record),
    .end_line   (bus.end_line),
    .end_frame  (bus.end_frame),
    .data_in    (bus.data_in),
    .wr_bank    (wr_bank),
    .write_addr (bus.write_addr),
    .we         (bus.we),
    .data_out   (bus.data_out),
    .drop       (drop),
    .last_line  (last_line)
  );

endmodule

// File: doc/frame_record_pp.md
# frame_record_pp

Parametrised ping-pong frame recorder. It sits between the sensor pixel-word stream and the dual-ported frame-buffer RAM. It converts `record`/`end_line`/`end_frame` strobes into linear RAM write addresses across two frame banks, so readout can drain one complete frame while the next is captured. It adds the following behaviour beyond a fixed-geometry recorder:
- arm/single-shot and continuous modes;
- selectable row order;
- overflow detection;
- a frame-complete handshake.

## Interface
Parameters:
- `DATA_W`, 64: pixel-word width.
- `X_COUNT`, 240: words per line.
- `Y_COUNT`, 1920: lines per frame.
- `BOTTOM_UP`, 1: 1 means the first captured line goes to row `Y_COUNT-1`; 0 means it goes to row 0.
- `ADDR_W`, 20: write-address width. Elaboration error if `2^ADDR_W < 2*X_COUNT*Y_COUNT`.

Ports:
- `pclock` in 1: pixel clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `arm` in 1: one-cycle request to capture starting at the next frame boundary.
- `continuous` in 1: level; when 1, keep capturing frames and alternate banks.
- `record` in 1: `data_in` is a valid pixel word this cycle.
- `end_line` in 1: line-boundary strobe.
- `end_frame` in 1: frame-boundary strobe.
- `data_in` in `DATA_W`: pixel word.
- `write_addr` out `ADDR_W`: RAM write address, registered.
- `we` out 1: RAM write enable, registered.
- `data_out` out `DATA_W`: RAM write data, registered.
- `wr_bank` out 1: bank currently being filled.
- `rd_bank` out 1: bank holding the most recent complete frame.
- `frame_done` out 1: one-cycle pulse when a frame completes.
- `busy` out 1: high when state is not IDLE.
- `last_line` out 1: line counter equals `Y_COUNT-1` while in CAPTURE.
- `overflow` out 1: sticky; cleared by `arm` or `reset`.

## Operation
- States are IDLE, WAIT_SOF and CAPTURE.
- IDLE:
  - `arm` moves to WAIT_SOF and clears `overflow`.
  - `arm` in any other state is ignored.
- WAIT_SOF:
  - `end_frame` zeroes the counters `xc`=0 and `lc`=0, then moves to CAPTURE.
  - `record` is ignored (`we`=0).
- CAPTURE, word handling:
  - `record` with `xc<X_COUNT` and `lc<Y_COUNT` writes `data_in` to `wr_bank*X_COUNT*Y_COUNT + row*X_COUNT + xc`, then `xc++`.
  - `row` is `Y_COUNT-1-lc` if `BOTTOM_UP`, else `lc`.
  - `record` with `xc==X_COUNT` or `lc==Y_COUNT` drops the word (`we`=0) and sets `overflow`.
- CAPTURE, line handling:
  - `end_line` sets `xc`=0 and increments `lc`, saturating at `Y_COUNT`.
- CAPTURE, frame handling:
  - `end_frame` asserts `frame_done` and sets `rd_bank<=wr_bank` and `wr_bank<=~wr_bank`.
  - If `continuous`=1, the block stays in CAPTURE with counters zeroed. Otherwise it goes to IDLE.
- Simultaneous events:
  - `record` together with `end_line` or `end_frame`: the word is written at the pre-strobe position, then the counters update.
  - `end_frame` has priority over `end_line`; the `end_line` is discarded.
- Short frames (fewer than `Y_COUNT` lines) still complete normally. Unwritten words keep their old contents.
- Address arithmetic is done in `ADDR_W` bits and cannot wrap, given the parameter check.

## Timing
- Reset values:
  - `write_addr`=0, `we`=0, `data_out`=0.
  - `wr_bank`=0, `rd_bank`=0, `frame_done`=0, `overflow`=0.
  - State is IDLE, so `busy`=0 and `last_line`=0.
- Latency is 1 cycle. A `record` at edge N produces `we`/`write_addr`/`data_out` valid after edge N+1.
- `frame_done`, `rd_bank` and `wr_bank` all update on the same edge, one cycle after `end_frame`.
- Readout may start from `rd_bank` on the cycle `frame_done` is high. The last data word's `we` is also on that cycle.
- `overflow` is registered and rises on the edge after the offending `record`.
- Reset mid-frame:
  - `we`=0 from the next edge and the state returns to IDLE.
  - No `frame_done` is produced and `rd_bank` is forced to 0.
- `continuous` is sampled only on the `end_frame` cycle.

## Structure
- Package `frame_record_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_WAIT_SOF`, `ST_CAPTURE`);
  - a constant function `frame_words(x,y)=x*y`;
  - the `ADDR_W` check helper.
- Sub-module `frame_addr_gen` holds the `xc`/`lc` counters, the row mapping, the bank offset, the write/drop decision and the registered output stage.
- The top level holds the FSM, the bank flip-flops and the `overflow`/`frame_done` logic.

## Test plan
- Single-shot, `X_COUNT`=4, `Y_COUNT`=3, `BOTTOM_UP`=1:
  - Stimulus: arm, `end_frame`, then 3 lines of 4 words, then `end_frame`.
  - Required writes: addresses 8..11, then 4..7, then 0..3.
  - Then one `frame_done` pulse, `rd_bank`=0, `wr_bank`=1, return to IDLE.
- Continuous, same geometry with `BOTTOM_UP`=0:
  - Frame 1 writes 0..11. Frame 2 writes 12..23.
  - `rd_bank` reads 0 then 1 at the two `frame_done` pulses.
- Overflow:
  - 5 `record`s on one line gives 4 writes. The fifth has `we`=0 and `overflow`=1 the next cycle.
  - A following `arm` clears `overflow`.
- Simultaneous strobes:
  - `record`+`end_line` at `xc`=3 writes the word at `xc`=3, then the next word goes to `xc`=0 of the next row.
  - `end_line`+`end_frame` together gives exactly one `frame_done` and no extra line increment.
- Reset mid-frame after 5 words:
  - `we`=0 next cycle and state IDLE.
  - No `frame_done`; all outputs at reset values.
- `record` during IDLE/WAIT_SOF produces no `we`. `arm` during CAPTURE has no effect.
